// File: rtl/a51_pkg.sv
// Shared types and constants for the A5/1 ciphertext serializer.
// Holds the emission state encoding, ASCII bases and the index-width helper.
package a51_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int A51_FRAME_BYTES = 28;

  localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
  localparam logic [7:0] ASCII_ALPHA_BASE = 8'h41;

  // At least one bit, so a single-character frame still has a legal index.
  function automatic int index_width(input int num_chars);
    return (num_chars > 1) ? $clog2(num_chars) : 1;
  endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Maps a 4-bit nibble to its upper-case ASCII hex digit.
// Purely combinational; the caller registers the result.
module nibble_to_ascii
  import a51_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_DIGIT_BASE + {4'd0, nibble};
    end else begin
      ascii = ASCII_ALPHA_BASE + ({4'd0, nibble} - 8'd10);
    end
  end

endmodule

// File: rtl/a51_cipher_serializer.sv
// Captures the A5/1 ciphertext word and replays it as paced LCD write strobes,
// either as raw bytes or as two ASCII hex characters per byte (byte 0 first).
module a51_cipher_serializer
  import a51_pkg::*;
#(
  parameter int NUM_BYTES  = A51_FRAME_BYTES,
  parameter int GAP_CYCLES = 50000,
  parameter int HEX_MODE   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [8*NUM_BYTES-1:0] cipher_in,
  input  logic                   abort,
  output logic [7:0]             char_out,
  output logic                   char_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int NUM_CHARS = (HEX_MODE != 0) ? 2 * NUM_BYTES : NUM_BYTES;
  localparam int IDX_W     = index_width(2 * NUM_BYTES);
  localparam int BYTE_W    = IDX_W - 1;
  localparam int CNT_W     = $clog2(GAP_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

  state_t                   state_reg;
  logic [8*NUM_BYTES-1:0]   shadow_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic [CNT_W-1:0]         gap_reg;
  logic [7:0]               char_out_reg;
  logic                     char_valid_reg;
  logic                     busy_reg;
  logic                     done_reg;
  logic                     overrun_reg;

  // The character is resolved one cycle ahead of its strobe so char_out can be
  // registered: from the live input on a load, from the shadow when leaving GAP.
  logic [8*NUM_BYTES-1:0]   sel_word;
  logic [IDX_W-1:0]         sel_idx;
  logic [BYTE_W-1:0]        sel_byte_idx;
  logic [7:0]               sel_bytes [NUM_BYTES];
  logic [7:0]               sel_byte;
  logic [3:0]               sel_nibble;
  logic [7:0]               nibble_char;
  logic [7:0]               sel_char;

  always_comb begin
    sel_word = (state_reg == GAP) ? shadow_reg : cipher_in;
    sel_idx  = (state_reg == GAP) ? idx_reg : '0;
  end

  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
      assign sel_bytes[gi] = sel_word[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    sel_byte_idx = (HEX_MODE != 0) ? sel_idx[IDX_W-1:1] : sel_idx[BYTE_W-1:0];
    sel_byte     = sel_bytes[sel_byte_idx];
    sel_nibble   = sel_idx[0] ? sel_byte[3:0] : sel_byte[7:4];
    sel_char     = (HEX_MODE != 0) ? nibble_char : sel_byte;
  end

  nibble_to_ascii u_nibble_to_ascii (
    .nibble (sel_nibble),
    .ascii  (nibble_char)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      shadow_reg     <= '0;
      idx_reg        <= '0;
      gap_reg        <= '0;
      char_out_reg   <= 8'h00;
      char_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      char_valid_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (load && !abort) begin
            shadow_reg     <= cipher_in;
            idx_reg        <= '0;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b1;
            char_out_reg   <= sel_char;
            char_valid_reg <= 1'b1;
            state_reg      <= EMIT;
          end
        end

        EMIT: begin
          if (abort) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            if (load) begin
              overrun_reg <= 1'b1;
            end
            if (idx_reg == LAST_IDX) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              gap_reg   <= GAP_LOAD;
              state_reg <= GAP;
            end
          end
        end

        GAP: begin
          if (abort) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            if (load) begin
              overrun_reg <= 1'b1;
            end
            if (gap_reg == CNT_W'(1)) begin
              char_out_reg   <= sel_char;
              char_valid_reg <= 1'b1;
              state_reg      <= EMIT;
            end else begin
              gap_reg <= gap_reg - 1'b1;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign char_out   = char_out_reg;
  assign char_valid = char_valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_a51_cipher_serializer.sv
// Drives a hex-mode and a raw-mode serializer with the same stimulus and checks
// both against a schedule-based reference model, cycle by cycle.
module tb_a51_cipher_serializer;

  localparam int NB  = 4;
  localparam int GAP = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        abort;
  logic [31:0] cipher_in;

  logic [7:0] co_h, co_r;
  logic       cv_h, cv_r, busy_h, busy_r, done_h, done_r, ovr_h, ovr_r;

  int total = 0;
  int bad   = 0;
  int gc    = 0;

  // Model state per instance: index 0 = hex mode, index 1 = raw mode.
  bit          m_run  [2];
  bit          m_done [2];
  bit          m_ovr  [2];
  int          m_s    [2];
  logic [31:0] m_word [2];
  logic [7:0]  m_last [2];

  always #5 clk = ~clk;

  a51_cipher_serializer #(.NUM_BYTES(NB), .GAP_CYCLES(GAP), .HEX_MODE(1)) dut_hex (
    .clk(clk), .reset(reset), .load(load), .cipher_in(cipher_in), .abort(abort),
    .char_out(co_h), .char_valid(cv_h), .busy(busy_h), .done(done_h), .overrun(ovr_h)
  );

  a51_cipher_serializer #(.NUM_BYTES(NB), .GAP_CYCLES(GAP), .HEX_MODE(0)) dut_raw (
    .clk(clk), .reset(reset), .load(load), .cipher_in(cipher_in), .abort(abort),
    .char_out(co_r), .char_valid(cv_r), .busy(busy_r), .done(done_r), .overrun(ovr_r)
  );

  function automatic int num_chars(input int d);
    return (d == 0) ? 2 * NB : NB;
  endfunction

  // Character k of a word, from the textual rules: byte 0 first, high nibble first.
  function automatic logic [7:0] exp_char(input int d, input logic [31:0] w, input int k);
    int b;
    int nib;
    b = int'((w >> (8 * ((d == 0) ? k / 2 : k))) & 32'hFF);
    if (d != 0) return 8'(b);
    nib = (k % 2 == 0) ? b / 16 : b % 16;
    return (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, gc, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_done[d] = 0; m_ovr[d] = 0;
      m_s[d] = 0; m_word[d] = '0; m_last[d] = 8'h00;
    end
  endtask

  // One clock cycle: apply inputs, check outputs of this cycle, advance the model.
  task automatic cyc(input bit ld, input bit ab, input bit rs, input logic [31:0] w);
    bit         ev;
    logic [7:0] ec;
    int         k;
    string      nm;
    load = ld; abort = ab; reset = rs; cipher_in = w;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      nm = (d == 0) ? "hex" : "raw";
      if (m_run[d] && gc > m_s[d] + (num_chars(d) - 1) * (GAP + 1)) begin
        m_run[d] = 0;
        m_done[d] = 1;
      end
      k  = gc - m_s[d];
      ev = m_run[d] && (k % (GAP + 1) == 0);
      if (ev) begin
        ec = exp_char(d, m_word[d], k / (GAP + 1));
        m_last[d] = ec;
      end
      check({nm, "_valid"},   {7'd0, (d == 0) ? cv_h : cv_r},     {7'd0, ev});
      check({nm, "_char"},    (d == 0) ? co_h : co_r,             m_last[d]);
      check({nm, "_busy"},    {7'd0, (d == 0) ? busy_h : busy_r}, {7'd0, m_run[d]});
      check({nm, "_done"},    {7'd0, (d == 0) ? done_h : done_r}, {7'd0, m_done[d]});
      check({nm, "_overrun"}, {7'd0, (d == 0) ? ovr_h : ovr_r},   {7'd0, m_ovr[d]});
      if ((d == 0 ? cv_h : cv_r) === 1'b1)
        $display("cycle %0d %s strobe char=%h", gc, nm, (d == 0) ? co_h : co_r);
    end
    for (int d = 0; d < 2; d++) begin
      if (rs) begin
        m_run[d] = 0; m_done[d] = 0; m_ovr[d] = 0; m_last[d] = 8'h00;
      end else if (ab) begin
        if (m_run[d]) begin
          m_run[d] = 0;
          m_done[d] = 0;
        end
      end else if (ld) begin
        if (m_run[d]) begin
          m_ovr[d] = 1;
        end else begin
          m_run[d] = 1; m_done[d] = 0; m_s[d] = gc + 1; m_word[d] = w;
        end
      end
    end
    @(posedge clk);
    #1;
    gc++;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; abort = 1'b0; cipher_in = '0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    // Reset state with reset still asserted
    cyc(0, 0, 1, 32'h0);

    // Hex and raw emission of a fixed word; cipher_in scrambled afterwards
    cyc(1, 0, 0, 32'hA51F003C);
    repeat (34) cyc(0, 0, 0, $urandom);

    // Reload from DONE
    cyc(1, 0, 0, 32'h0000000A);
    repeat (34) cyc(0, 0, 0, $urandom);

    // abort+load from DONE is a no-op; abort alone in DONE has no effect
    cyc(1, 1, 0, $urandom);
    cyc(0, 1, 0, $urandom);
    repeat (3) cyc(0, 0, 0, $urandom);

    // Load while busy is ignored and flags overrun
    cyc(1, 0, 0, 32'hA51F003C);
    repeat (5) cyc(0, 0, 0, 32'hA51F003C);
    cyc(1, 0, 0, 32'hFFFFFFFF);
    repeat (30) cyc(0, 0, 0, 32'hFFFFFFFF);

    // Abort mid-emission, then restart from byte 0
    cyc(1, 0, 0, 32'hA51F003C);
    repeat (6) cyc(0, 0, 0, $urandom);
    cyc(0, 1, 0, $urandom);
    repeat (3) cyc(0, 0, 0, $urandom);
    cyc(1, 0, 0, $urandom);
    repeat (34) cyc(0, 0, 0, $urandom);

    // Reset mid-emission, then a fresh load
    cyc(1, 0, 0, 32'hA51F003C);
    repeat (9) cyc(0, 0, 0, $urandom);
    cyc(0, 0, 1, $urandom);
    cyc(0, 0, 0, $urandom);
    cyc(1, 0, 0, 32'hA51F003C);
    repeat (34) cyc(0, 0, 0, $urandom);

    // Random mix of loads, aborts and resets
    repeat (400) cyc(($urandom % 16) == 0, ($urandom % 48) == 0, ($urandom % 200) == 0, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
